tick_rr_sched: RTL and testbench

//  Round-robin scheduler for the shared slow tick produced by clk_div.

---
 rtl/tick_rr_sched.sv | 117 +++++++++++
 tb/tb_tick_rr_sched.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/tick_rr_sched.sv
// tick_rr_sched: round-robin scheduler for the shared slow tick from clk_div.
// Each clk_en pulse produces at most one single-cycle grant to one of NREQ
// requesters, so several slow consumers can share one divider. Per-requester
// wait counters saturate to flag starvation for debug.
//
// Ports:
//   clk          system clock
//   rst          synchronous reset, active-high
//   clk_en       one-cycle tick from clk_div
//   req          level request per requester, held until granted
//   grant        one-hot grant pulse, registered, one cycle after the tick
//   grant_valid  |grant
//   grant_id     index of the last granted requester (holds between grants)
//   busy         registered |req
//   starve       wait counter of requester i is saturated
module tick_rr_sched #(
   parameter int unsigned NREQ   = 4,
   parameter int unsigned WAIT_W = 4,
   localparam int unsigned IDW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            clk_en,
   input  logic [NREQ-1:0] req,
   output logic [NREQ-1:0] grant,
   output logic            grant_valid,
   output logic [IDW-1:0]  grant_id,
   output logic            busy,
   output logic [NREQ-1:0] starve
);

   logic [IDW-1:0]    ptr_q, ptr_d;
   logic [NREQ-1:0]   grant_q, grant_d;
   logic [IDW-1:0]    grant_id_q, grant_id_d;
   logic              busy_q;
   logic [WAIT_W-1:0] wait_q [NREQ];
   logic [WAIT_W-1:0] wait_d [NREQ];

   logic              win_found;
   logic [IDW-1:0]    win_idx;
   logic [IDW:0]      scan_idx;

   // Scan ptr, ptr+1, ... wrapping at NREQ; first set request wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      scan_idx  = '0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         scan_idx = {1'b0, ptr_q} + (IDW+1)'(k);
         if (scan_idx >= (IDW+1)'(NREQ)) begin
            scan_idx = scan_idx - (IDW+1)'(NREQ);
         end
         if (!win_found && req[scan_idx[IDW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = scan_idx[IDW-1:0];
         end
      end
   end

   always_comb begin
      ptr_d      = ptr_q;
      grant_d    = '0;
      grant_id_d = grant_id_q;
      if (clk_en && win_found) begin
         grant_d[win_idx] = 1'b1;
         grant_id_d       = win_idx;
         if (win_idx == IDW'(NREQ - 1)) begin
            ptr_d = '0;
         end else begin
            ptr_d = win_idx + IDW'(1);
         end
      end
   end

   // Wait counters only move on ticks; a tick with the requester idle or
   // winning clears it, otherwise it counts up and sticks at all-ones.
   always_comb begin
      starve = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         wait_d[i] = wait_q[i];
         starve[i] = &wait_q[i];
         if (clk_en) begin
            if (!req[i] || (win_found && win_idx == IDW'(i))) begin
               wait_d[i] = '0;
            end else if (!(&wait_q[i])) begin
               wait_d[i] = wait_q[i] + WAIT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q      <= '0;
         grant_q    <= '0;
         grant_id_q <= '0;
         busy_q     <= 1'b0;
         for (int unsigned i = 0; i < NREQ; i++) begin
            wait_q[i] <= '0;
         end
      end else begin
         ptr_q      <= ptr_d;
         grant_q    <= grant_d;
         grant_id_q <= grant_id_d;
         busy_q     <= |req;
         for (int unsigned i = 0; i < NREQ; i++) begin
            wait_q[i] <= wait_d[i];
         end
      end
   end

   assign grant       = grant_q;
   assign grant_valid = |grant_q;
   assign grant_id    = grant_id_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_tick_rr_sched.sv
// Bench for tick_rr_sched (NREQ=4, WAIT_W=2 so starvation is reachable).
module tb_tick_rr_sched;

   localparam int NREQ = 4;
   localparam int MAXW = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       clk_en = 1'b0;
   logic [3:0] req = '0;
   logic [3:0] grant;
   logic       grant_valid;
   logic [1:0] grant_id;
   logic       busy;
   logic [3:0] starve;

   int total = 0;
   int bad   = 0;

   // Reference model state
   int         m_ptr;
   int         m_wait [NREQ];
   logic [3:0] m_grant;
   int         m_gid;
   bit         m_busy;

   tick_rr_sched #(
      .NREQ   (4),
      .WAIT_W (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .clk_en      (clk_en),
      .req         (req),
      .grant       (grant),
      .grant_valid (grant_valid),
      .grant_id    (grant_id),
      .busy        (busy),
      .starve      (starve)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_ptr = 0; m_grant = '0; m_gid = 0; m_busy = 1'b0;
      for (int i = 0; i < NREQ; i++) m_wait[i] = 0;
   endtask

   task automatic model_update(input bit r, input bit e, input logic [3:0] q);
      int w;
      if (r) begin
         model_reset();
      end else begin
         m_busy  = |q;
         m_grant = '0;
         if (e) begin
            w = -1;
            for (int k = 0; k < NREQ; k++) begin
               if (w < 0 && q[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
            end
            for (int i = 0; i < NREQ; i++) begin
               if (w == i || !q[i]) m_wait[i] = 0;
               else if (m_wait[i] < MAXW) m_wait[i] = m_wait[i] + 1;
            end
            if (w >= 0) begin
               m_grant = 4'(1 << w);
               m_gid   = w;
               m_ptr   = (w + 1) % NREQ;
            end
         end
      end
   endtask

   function automatic logic [3:0] model_starve();
      logic [3:0] s;
      for (int i = 0; i < NREQ; i++) s[i] = (m_wait[i] == MAXW);
      return s;
   endfunction

   // Apply one cycle of inputs, advance the model, compare all outputs.
   task automatic step(input bit r, input bit e, input logic [3:0] q);
      @(negedge clk);
      rst = r; clk_en = e; req = q;
      @(posedge clk);
      model_update(r, e, q);
      #1;
      check("grant", 32'(grant), 32'(m_grant));
      check("grant_valid", 32'(grant_valid), 32'(|m_grant));
      check("grant_id", 32'(grant_id), 32'(m_gid));
      check("busy", 32'(busy), 32'(m_busy));
      check("starve", 32'(starve), 32'(model_starve()));
   endtask

   typedef struct {
      bit         r;
      bit         e;
      logic [3:0] q;
      logic [3:0] exp_grant;
      logic [1:0] exp_gid;
   } vec_t;

   vec_t vecs [$];

   function automatic vec_t mk(bit r, bit e, logic [3:0] q, logic [3:0] g, logic [1:0] id);
      vec_t v;
      v.r = r; v.e = e; v.q = q; v.exp_grant = g; v.exp_gid = id;
      return v;
   endfunction

   initial begin
      model_reset();

      // Reset held with requests and ticks present
      for (int i = 0; i < 5; i++) vecs.push_back(mk(1, (i % 2) == 0, 4'hF, 4'h0, 2'd0));
      vecs.push_back(mk(0, 0, 4'hF, 4'h0, 2'd0));
      // All requesting: rotating grants, one cycle each
      for (int i = 0; i < 8; i++) begin
         vecs.push_back(mk(0, 1, 4'hF, 4'(1 << (i % 4)), 2'(i % 4)));
         vecs.push_back(mk(0, 0, 4'hF, 4'h0, 2'(i % 4)));
      end
      // Single requester moves ptr to 3, then 3 beats 0
      vecs.push_back(mk(0, 1, 4'h4, 4'h4, 2'd2));
      vecs.push_back(mk(0, 0, 4'h9, 4'h0, 2'd2));
      vecs.push_back(mk(0, 1, 4'h9, 4'h8, 2'd3));
      vecs.push_back(mk(0, 1, 4'h9, 4'h1, 2'd0));
      vecs.push_back(mk(0, 0, 4'h0, 4'h0, 2'd0));
      // Dropped ticks and off-tick requests; ptr stays 1
      vecs.push_back(mk(0, 1, 4'h0, 4'h0, 2'd0));
      vecs.push_back(mk(0, 0, 4'hF, 4'h0, 2'd0));
      vecs.push_back(mk(0, 0, 4'h0, 4'h0, 2'd0));
      vecs.push_back(mk(0, 1, 4'h0, 4'h0, 2'd0));
      vecs.push_back(mk(0, 1, 4'h3, 4'h2, 2'd1));
      // Back-to-back ticks
      vecs.push_back(mk(0, 1, 4'h3, 4'h1, 2'd0));
      vecs.push_back(mk(0, 1, 4'h3, 4'h2, 2'd1));
      vecs.push_back(mk(0, 1, 4'h3, 4'h1, 2'd0));
      vecs.push_back(mk(0, 0, 4'h0, 4'h0, 2'd0));

      foreach (vecs[i]) begin
         step(vecs[i].r, vecs[i].e, vecs[i].q);
         check($sformatf("vec%0d_grant", i), 32'(grant), 32'(vecs[i].exp_grant));
         check($sformatf("vec%0d_gid", i), 32'(grant_id), 32'(vecs[i].exp_gid));
      end

      // Starvation: with WAIT_W=2, req=1111 from reset leaves index 3 waiting
      // three ticks, which saturates its counter; its own grant clears it.
      step(1, 0, 4'h0);
      step(0, 1, 4'hF);
      step(0, 1, 4'hF);
      check("starve3_before", 32'(starve[3]), 32'd0);
      step(0, 1, 4'hF);
      check("starve3_set", 32'(starve[3]), 32'd1);
      check("starve_set_vec", 32'(starve), 32'h8);
      step(0, 0, 4'hF);
      check("starve3_hold", 32'(starve[3]), 32'd1);
      step(0, 1, 4'hF);
      check("grant3", 32'(grant), 32'h8);
      check("starve3_clear", 32'(starve[3]), 32'd0);
      check("starve0_set", 32'(starve[0]), 32'd1);

      // Randomised traffic against the model
      for (int n = 0; n < 600; n++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 2) != 0),
              4'($urandom_range(0, 15)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
